// File: rtl/rf_operand_fetch.sv
// ID-stage operand fetch: drives the register file read/write ports, bypasses same-cycle
// writeback, interlocks RAW/WAW hazards with a busy-bit scoreboard, and registers operands for EX.

module rf_opsel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      src,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [2**ADDR_W-1:0]   busy,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic [DATA_W-1:0]      opnd,
  output logic                   blocked
);
  logic is_r0, wb_hit;

  always_comb begin
    is_r0   = (src == '0);
    wb_hit  = wb_valid && (wb_addr == src);
    // The file write only lands at the edge, so a matching writeback must be forwarded.
    opnd    = is_r0 ? '0 : (wb_hit ? wb_data : rdata);
    blocked = !is_r0 && busy[src] && !wb_hit;
  end
endmodule

module rf_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  output logic [ADDR_W-1:0] raddr1,
  input  logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int NUM_SRC = 2;
  localparam int NREG    = 2**ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] rd;
    logic              rd_we;
  } opnd_t;

  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_rdata;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]             src_blk;

  logic [NREG-1:0] busy, busy_nxt;
  opnd_t           out_q;
  logic            vld_q;
  logic            rd_blk, hazard, accept;

  assign src_addr[0]  = in_rs1;
  assign src_addr[1]  = in_rs2;
  assign src_rdata[0] = rdata1;
  assign src_rdata[1] = rdata2;
  assign raddr1       = in_rs1;
  assign raddr2       = in_rs2;

  assign we    = wb_valid && (wb_addr != '0);
  assign waddr = wb_addr;
  assign wdata = wb_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    rf_opsel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel (
      .src     (src_addr[g]),
      .rdata   (src_rdata[g]),
      .busy    (busy),
      .wb_valid(wb_valid),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .opnd    (src_data[g]),
      .blocked (src_blk[g])
    );
  end

  // WAW: a second writer to a still-busy destination waits unless its writeback is arriving now.
  assign rd_blk   = in_rd_we && (in_rd != '0) && busy[in_rd] &&
                    !(wb_valid && (wb_addr == in_rd));
  assign hazard   = in_valid && ((|src_blk) || rd_blk);
  assign in_ready = (!vld_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear first, then set, so an issue to the register being written back keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_addr] = 1'b0;
    if (accept && in_rd_we && (in_rd != '0)) busy_nxt[in_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= 1'b0;
      out_q <= '0;
    end else if (accept) begin
      vld_q       <= 1'b1;
      out_q.src1  <= src_data[0];
      out_q.src2  <= src_data[1];
      out_q.rd    <= in_rd;
      out_q.rd_we <= in_rd_we;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld_q;
  assign out_src1  = out_q.src1;
  assign out_src2  = out_q.src2;
  assign out_rd    = out_q.rd;
  assign out_rd_we = out_q.rd_we;
endmodule
